// File: rtl/data_dma_if.sv
// data_dma_if: RAM-side bus of the data_dma copy engine.
// The master modport is the initiator (drives address/write), the slave modport
// is the RAM (returns combinational read data).
interface data_dma_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     Data_WE;
    logic [ADDRESS_WIDTH-1:0] Data_addr;
    logic [DATA_WIDTH-1:0]    Data_WD;
    logic [DATA_WIDTH-1:0]    Data_RD;

    modport master (
        output Data_WE,
        output Data_addr,
        output Data_WD,
        input  Data_RD
    );

    modport slave (
        input  Data_WE,
        input  Data_addr,
        input  Data_WD,
        output Data_RD
    );
endinterface

// File: rtl/data_dma.sv
// data_dma: word-granular copy engine for the data RAM port.
// After an accepted start it copies word_count words from src_addr to dst_addr,
// one READ cycle followed by one WRITE cycle per word, stepping both pointers by 4.
// Optional feature macro DATA_DMA_CHECKSUM_EN adds a running 32-bit sum of all
// words read, exposed on the checksum port.
// Only DATA_WIDTH = 32 is meaningful: the byte step of 4 assumes 32-bit words.
module data_dma #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] src_addr,
    input  logic [ADDRESS_WIDTH-1:0] dst_addr,
    input  logic [COUNT_WIDTH-1:0]   word_count,
    output logic                     busy,
    output logic                     done,
    data_dma_if.master               ram
`ifdef DATA_DMA_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]    checksum
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(4);

    logic [1:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] src_ptr_q, src_ptr_d;
    logic [ADDRESS_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
    logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0]    rd_buf_q, rd_buf_d;
`ifdef DATA_DMA_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]    checksum_q, checksum_d;
`endif

    // Next-state logic: sequence IDLE -> READ/WRITE pairs -> DONE -> IDLE.
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        rd_buf_d    = rd_buf_q;
`ifdef DATA_DMA_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_ptr_d   = src_addr;
                    dst_ptr_d   = dst_addr;
                    remaining_d = word_count;
`ifdef DATA_DMA_CHECKSUM_EN
                    checksum_d  = '0;
`endif
                    state_d     = (word_count == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                rd_buf_d  = ram.Data_RD;
                src_ptr_d = src_ptr_q + ADDR_STEP;
`ifdef DATA_DMA_CHECKSUM_EN
                checksum_d = checksum_q + ram.Data_RD;
`endif
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                dst_ptr_d   = dst_ptr_q + ADDR_STEP;
                remaining_d = remaining_q - COUNT_WIDTH'(1);
                state_d     = (remaining_q == COUNT_WIDTH'(1)) ? ST_DONE : ST_READ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            rd_buf_q    <= '0;
`ifdef DATA_DMA_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            rd_buf_q    <= rd_buf_d;
`ifdef DATA_DMA_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    // Output decode from registered state only; the write strobe is also gated by
    // rst_n so a write cannot commit on the same edge that resets the engine.
    always_comb begin
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DONE);
        ram.Data_WE   = (state_q == ST_WRITE) && rst_n;
        ram.Data_addr = '0;
        ram.Data_WD   = '0;
        if (state_q == ST_READ) begin
            ram.Data_addr = src_ptr_q;
        end else if (state_q == ST_WRITE) begin
            ram.Data_addr = dst_ptr_q;
            ram.Data_WD   = rd_buf_q;
        end
    end

`ifdef DATA_DMA_CHECKSUM_EN
    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_data_dma.sv
// tb_data_dma: self-checking bench for data_dma with an 8-bit address space
// (256-byte RAM, big-endian word view) so wrap-around is easy to reach.
// A behavioural copy model predicts memory contents, the RAM access trace,
// completion timing and (with DATA_DMA_CHECKSUM_EN) the checksum.
module tb_data_dma;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [CW-1:0] word_count;
    logic          busy;
    logic          done;
`ifdef DATA_DMA_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    always #5 clk = ~clk;

    data_dma_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) ram_if ();

    data_dma #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .word_count(word_count),
        .busy      (busy),
        .done      (done),
        .ram       (ram_if)
`ifdef DATA_DMA_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    // RAM: combinational big-endian read, byte-addressed write at the clock edge.
    assign ram_if.Data_RD = {mem[ram_if.Data_addr],
                             mem[ram_if.Data_addr + 8'd1],
                             mem[ram_if.Data_addr + 8'd2],
                             mem[ram_if.Data_addr + 8'd3]};

    always @(posedge clk) begin
        if (ram_if.Data_WE) begin
            mem[ram_if.Data_addr]         <= ram_if.Data_WD[31:24];
            mem[ram_if.Data_addr + 8'd1]  <= ram_if.Data_WD[23:16];
            mem[ram_if.Data_addr + 8'd2]  <= ram_if.Data_WD[15:8];
            mem[ram_if.Data_addr + 8'd3]  <= ram_if.Data_WD[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_byte(input logic [7:0] a, input logic [7:0] v);
        mem[a]     <= v;
        ref_mem[a] = v;
    endtask

    task automatic set_word(input logic [7:0] a, input logic [31:0] w);
        set_byte(a,        w[31:24]);
        set_byte(a + 8'd1, w[23:16]);
        set_byte(a + 8'd2, w[15:8]);
        set_byte(a + 8'd3, w[7:0]);
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        return {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
    endfunction

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
    endfunction

    task automatic check_mem(input string tag);
        int diff = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) diff++;
        end
        check({tag, " mem_diff"}, diff, 0);
    endtask

    task automatic random_fill();
        for (int i = 0; i < 256; i++) set_byte(8'(i), 8'($urandom));
    endtask

    // Run one copy from the current cycle: start is accepted at the next edge (edge 0).
    // Returns in the idle cycle after DONE, at the falling edge.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input int n,
                            input bit repulse, input string tag);
        logic [7:0]  exp_ra[$];
        logic [7:0]  exp_wa[$];
        logic [31:0] exp_wd[$];
        logic [7:0]  got_ra[$];
        logic [7:0]  got_wa[$];
        logic [31:0] got_wd[$];
        logic [31:0] exp_sum = '0;
        logic [31:0] w;
        int          last;
        int          done_cnt = 0;
        int          done_cyc = -1;
        int          busy_cnt = 0;

        // Reference: word i is read from the memory as it stands after words 0..i-1 were written.
        for (int i = 0; i < n; i++) begin
            w = ref_word(s + 8'(4 * i));
            exp_ra.push_back(s + 8'(4 * i));
            exp_sum = exp_sum + w;
            exp_wa.push_back(d + 8'(4 * i));
            exp_wd.push_back(w);
            ref_mem[d + 8'(4 * i)]        = w[31:24];
            ref_mem[d + 8'(4 * i) + 8'd1] = w[23:16];
            ref_mem[d + 8'(4 * i) + 8'd2] = w[15:8];
            ref_mem[d + 8'(4 * i) + 8'd3] = w[7:0];
        end
        last = (n == 0) ? 1 : 2 * n + 1;

        src_addr   = s;
        dst_addr   = d;
        word_count = CW'(n);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        src_addr   = 8'($urandom);
        dst_addr   = 8'($urandom);
        word_count = 8'($urandom);

        for (int c = 1; c <= last; c++) begin
            start = repulse && (c <= 5);
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (ram_if.Data_WE) begin
                got_wa.push_back(ram_if.Data_addr);
                got_wd.push_back(ram_if.Data_WD);
            end else if (busy && !done) begin
                got_ra.push_back(ram_if.Data_addr);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        @(negedge clk);

        check({tag, " done_cycle"}, done_cyc, last);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " busy_cycles"}, busy_cnt, last);
        check({tag, " idle_busy"}, busy, 1'b0);
        check({tag, " idle_done"}, done, 1'b0);
        check({tag, " n_writes"}, got_wa.size(), n);
        check({tag, " n_reads"}, got_ra.size(), n);
        for (int i = 0; i < n && i < got_wa.size(); i++) begin
            check($sformatf("%s waddr%0d", tag, i), got_wa[i], exp_wa[i]);
            check($sformatf("%s wdata%0d", tag, i), got_wd[i], exp_wd[i]);
        end
        for (int i = 0; i < n && i < got_ra.size(); i++) begin
            check($sformatf("%s raddr%0d", tag, i), got_ra[i], exp_ra[i]);
        end
        check_mem(tag);
`ifdef DATA_DMA_CHECKSUM_EN
        check({tag, " checksum"}, checksum, exp_sum);
`endif
        $display("copy %s: src=0x%02h dst=0x%02h n=%0d done_cycle=%0d writes=%0d", tag, s, d, n,
                 done_cyc, got_wa.size());
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        word_count = '0;
        random_fill();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset we", ram_if.Data_WE, 1'b0);
        check("reset addr", ram_if.Data_addr, 8'h00);
        check("reset wd", ram_if.Data_WD, 32'h0);
`ifdef DATA_DMA_CHECKSUM_EN
        check("reset checksum", checksum, 32'h0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic block move of bytes 00..0F.
        for (int i = 0; i < 16; i++) set_byte(8'(i), 8'(i));
        @(negedge clk);
        run_copy(8'h00, 8'h40, 4, 1'b0, "basic");
        for (int i = 0; i < 16; i++) check($sformatf("basic byte%0d", i), mem[8'h40 + 8'(i)], 8'(i));
`ifdef DATA_DMA_CHECKSUM_EN
        check("basic checksum_const", checksum, 32'h181C2024);
`endif

        // Zero-length request.
        run_copy(8'h10, 8'h20, 0, 1'b0, "zero");

        // Overlapping forward copy replicates the first word.
        set_word(8'h80, 32'hDEADBEEF);
        @(negedge clk);
        run_copy(8'h80, 8'h84, 3, 1'b0, "fill");
        check("fill w84", mem_word(8'h84), 32'hDEADBEEF);
        check("fill w88", mem_word(8'h88), 32'hDEADBEEF);
        check("fill w8C", mem_word(8'h8C), 32'hDEADBEEF);

        // start held during cycles 1..5 is ignored; next start accepted back to back.
        run_copy(8'h30, 8'hA0, 3, 1'b1, "repulse");
        run_copy(8'h50, 8'hC0, 2, 1'b0, "b2b");

        // Reset during the second WRITE (cycle 4) of a 4-word copy.
        begin
            logic [31:0] w0;
            w0 = ref_word(8'h20);
            ref_mem[8'h60] = w0[31:24];
            ref_mem[8'h61] = w0[23:16];
            ref_mem[8'h62] = w0[15:8];
            ref_mem[8'h63] = w0[7:0];
            src_addr   = 8'h20;
            dst_addr   = 8'h60;
            word_count = 8'd4;
            start      = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int c = 1; c <= 3; c++) begin
                @(posedge clk);
                #1;
            end
            rst_n = 1'b0;
            @(negedge clk);
            check("rst we_gated", ram_if.Data_WE, 1'b0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(negedge clk);
            check("rst busy", busy, 1'b0);
            check("rst done", done, 1'b0);
            check("rst we", ram_if.Data_WE, 1'b0);
            check_mem("rst");
`ifdef DATA_DMA_CHECKSUM_EN
            check("rst checksum", checksum, 32'h0);
`endif
            $display("reset during copy: src=0x20 dst=0x60 n=4 aborted at cycle 4");
        end
        run_copy(8'h24, 8'hD0, 1, 1'b0, "after_rst");

        // Address wrap-around in an 8-bit space.
        run_copy(8'hF8, 8'h10, 4, 1'b0, "wrap");

        // Randomized copies over a freshly randomized memory.
        random_fill();
        @(negedge clk);
        for (int t = 0; t < 20; t++) begin
            run_copy(8'($urandom), 8'($urandom), int'($urandom_range(0, 6)), 1'($urandom),
                     $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
